// File: rtl/mem_arbiter_if.sv
// Bundle of requester command/response channels and the memory port of mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment
// (both requesters plus the memory) driving the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR = 4,
    parameter int WORD = 4
) ();
    logic            req0_valid;
    logic            req0_wr;
    logic [ADDR-1:0] req0_addr;
    logic [WORD-1:0] req0_wdata;
    logic            req0_ready;
    logic            rsp0_valid;
    logic [WORD-1:0] rsp0_rdata;

    logic            req1_valid;
    logic            req1_wr;
    logic [ADDR-1:0] req1_addr;
    logic [WORD-1:0] req1_wdata;
    logic            req1_ready;
    logic            rsp1_valid;
    logic [WORD-1:0] rsp1_rdata;

    logic [ADDR-1:0] mem_addr;
    logic [WORD-1:0] mem_data_in;
    logic            mem_wr;
    logic [WORD-1:0] mem_data_out;

    modport slave (
        input  req0_valid, req0_wr, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_wr, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_addr, mem_data_in, mem_wr,
        input  mem_data_out
    );

    modport master (
        output req0_valid, req0_wr, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_wr, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_addr, mem_data_in, mem_wr,
        output mem_data_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between two requesters.
// One transaction in flight at a time; commands are only accepted in IDLE.
// Ties are broken round-robin on the last winner (rr_last), port 0 first after reset.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: port 0 always wins ties instead.
// Read data is captured RD_LAT clocks after mem_addr is driven and returned
// with a one-cycle pulse one clock later.
module mem_arbiter #(
    parameter int ADDR   = 4,
    parameter int WORD   = 4,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    // cnt runs 0..RD_LAT inside READ; RD_LAT is at most 3 so two bits suffice
    localparam logic [1:0] CAP_CNT = 2'(RD_LAT - 1);
    localparam logic [1:0] RSP_CNT = 2'(RD_LAT);

    state_t          state_q, state_d;
    logic            rr_last_q, rr_last_d;
    logic            cur_q, cur_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [WORD-1:0] mem_data_in_q, mem_data_in_d;
    logic            mem_wr_q, mem_wr_d;
    logic            rsp0_valid_q, rsp0_valid_d;
    logic            rsp1_valid_q, rsp1_valid_d;
    logic [WORD-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [WORD-1:0] rsp1_rdata_q, rsp1_rdata_d;

    logic            win;
    logic            accept;
    logic            win_wr;
    logic [ADDR-1:0] win_addr;
    logic [WORD-1:0] win_wdata;

    // Pick the winning port and decide whether a command is taken this cycle
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~rr_last_q;
`endif
        end else begin
            win = bus.req1_valid;
        end
        accept    = rst_n && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
        win_wr    = win ? bus.req1_wr    : bus.req0_wr;
        win_addr  = win ? bus.req1_addr  : bus.req0_addr;
        win_wdata = win ? bus.req1_wdata : bus.req0_wdata;
    end

    assign bus.req0_ready  = accept && !win;
    assign bus.req1_ready  = accept && win;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp0_rdata  = rsp0_rdata_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp1_rdata  = rsp1_rdata_q;

    // Next-state and next-output logic of the IDLE/WRITE/READ sequencer
    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        cur_d         = cur_q;
        cnt_d         = cnt_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_wr_d      = 1'b0;
        rsp0_valid_d  = 1'b0;
        rsp1_valid_d  = 1'b0;
        rsp0_rdata_d  = rsp0_rdata_q;
        rsp1_rdata_d  = rsp1_rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_addr_d    = win_addr;
                    mem_data_in_d = win_wdata;
                    rr_last_d     = win;
                    cur_d         = win;
                    if (win_wr) begin
                        mem_wr_d = 1'b1;
                        state_d  = WRITE;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == CAP_CNT) begin
                    if (cur_q) begin
                        rsp1_rdata_d = bus.mem_data_out;
                    end else begin
                        rsp0_rdata_d = bus.mem_data_out;
                    end
                end
                if (cnt_q == RSP_CNT) begin
                    rsp0_valid_d = !cur_q;
                    rsp1_valid_d = cur_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_last_q     <= 1'b1;
            cur_q         <= 1'b0;
            cnt_q         <= 2'd0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_wr_q      <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_rdata_q  <= '0;
            rsp1_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            cur_q         <= cur_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_wr_q      <= mem_wr_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_rdata_q  <= rsp0_rdata_d;
            rsp1_rdata_q  <= rsp1_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two requester drivers, a memory model and a
// transaction-level reference (ref_mem contents, last tie winner, occupancy arithmetic).
module tb_mem_arbiter;
    localparam int ADDR   = 4;
    localparam int WORD   = 4;
    localparam int RD_LAT = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR(ADDR), .WORD(WORD)) bus ();

    mem_arbiter #(.ADDR(ADDR), .WORD(WORD), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rsp0_cnt = 0;
    int rsp1_cnt = 0;
    int both_ready_cnt = 0;

    // memory model: write on posedge, read data valid RD_LAT clocks after the address
    logic [WORD-1:0] mem_array [16];
    logic [WORD-1:0] rd_pipe [2];
    bit mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 16; i++) mem_array[i] <= '0;
            mem_init_done <= 1'b1;
        end else if (bus.mem_wr === 1'b1) begin
            mem_array[bus.mem_addr] <= bus.mem_data_in;
        end
        rd_pipe[0] <= mem_array[bus.mem_addr];
        rd_pipe[1] <= rd_pipe[0];
    end

    assign bus.mem_data_out = (RD_LAT == 1) ? mem_array[bus.mem_addr] :
                              (RD_LAT == 2) ? rd_pipe[0] : rd_pipe[1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both_ready_cnt <= both_ready_cnt + 1;
    end

    always @(negedge clk) begin
        if (bus.rsp0_valid === 1'b1) rsp0_cnt <= rsp0_cnt + 1;
        if (bus.rsp1_valid === 1'b1) rsp1_cnt <= rsp1_cnt + 1;
    end

    // reference model state
    logic [WORD-1:0] ref_mem [16];
    int ref_last = 1;
    int exp0 [4];
    int exp1 [4];

    function automatic int winner(input bit v0, input bit v1);
        int w;
        if (v0 && v1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = (ref_last == 0) ? 1 : 0;
`endif
        end else begin
            w = v1 ? 1 : 0;
        end
        ref_last = w;
        return w;
    endfunction

    // expected accept cycles when both ports stream writes; each write holds the port 2 cycles
    function automatic void plan_writes(input int n0, input int n1, input int start);
        int k0 = 0;
        int k1 = 0;
        int t = start + 1;
        while (k0 < n0 || k1 < n1) begin
            if (winner(k0 < n0, k1 < n1) == 0) begin
                exp0[k0] = t;
                k0++;
            end else begin
                exp1[k1] = t;
                k1++;
            end
            t += 2;
        end
    endfunction

    task automatic drive(input int port, input bit v, input bit wr, input logic [3:0] a, input logic [3:0] d);
        if (port == 0) begin
            bus.req0_valid = v;
            bus.req0_wr    = wr;
            bus.req0_addr  = a;
            bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v;
            bus.req1_wr    = wr;
            bus.req1_addr  = a;
            bus.req1_wdata = d;
        end
    endtask

    // issue one command and hold it until accepted; optionally wait for the read response
    task automatic send(input int port, input bit wr, input logic [3:0] a, input logic [3:0] d,
                        input bit wait_rsp, output int acc_cyc, output int rsp_cyc, output logic [3:0] rdata);
        bit ok = 1'b0;
        acc_cyc = -1;
        rsp_cyc = -1;
        rdata   = '0;
        drive(port, 1'b1, wr, a, d);
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            if ((port == 0 && bus.req0_ready === 1'b1) || (port == 1 && bus.req1_ready === 1'b1)) begin
                ok = 1'b1;
                acc_cyc = cyc + 1;
            end
            @(negedge clk);
        end
        drive(port, 1'b0, wr, a, d);
        if (ok && wait_rsp && !wr) begin
            for (int i = 0; i < 20 && rsp_cyc < 0; i++) begin
                if (port == 0 && bus.rsp0_valid === 1'b1) begin
                    rsp_cyc = cyc;
                    rdata = bus.rsp0_rdata;
                end else if (port == 1 && bus.rsp1_valid === 1'b1) begin
                    rsp_cyc = cyc;
                    rdata = bus.rsp1_rdata;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_last = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({bus.mem_wr, bus.mem_addr, bus.mem_data_in} !== 9'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_mem_port: got %b, want 0", {bus.mem_wr, bus.mem_addr, bus.mem_data_in});
        end
        n_cmp++;
        if ({bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid, bus.rsp1_rdata} !== 10'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_rsp: got %b, want 0", {bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid, bus.rsp1_rdata});
        end
        #1;
        n_cmp++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL reset_ready: got %b, want 00", {bus.req0_ready, bus.req1_ready});
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int start, acc, rc, w;
        logic [3:0] rd;
        start = cyc;
        w = winner(1'b1, 1'b0);
        send(0, 1'b1, 4'd2, 4'd7, 1'b0, acc, rc, rd);
        ref_mem[2] = 4'd7;
        n_cmp++;
        if (acc !== start + 1) begin
            n_bad++;
            $display("[TB] FAIL wr_accept_p%0d: got cycle %0d, want %0d", w, acc, start + 1);
        end
        n_cmp++;
        if ({bus.mem_wr, bus.mem_addr, bus.mem_data_in} !== {1'b1, 4'd2, 4'd7}) begin
            n_bad++;
            $display("[TB] FAIL mem_write_drive: got wr=%b addr=%0d data=%0d, want 1/2/7", bus.mem_wr, bus.mem_addr, bus.mem_data_in);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.mem_wr !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL mem_wr_one_cycle: got %b, want 0", bus.mem_wr);
        end
        start = cyc;
        w = winner(1'b0, 1'b1);
        send(1, 1'b0, 4'd2, 4'd0, 1'b1, acc, rc, rd);
        n_cmp++;
        if (acc !== start + 1) begin
            n_bad++;
            $display("[TB] FAIL rd_accept_p%0d: got cycle %0d, want %0d", w, acc, start + 1);
        end
        n_cmp++;
        if (rc !== acc + RD_LAT + 1 || rd !== ref_mem[2]) begin
            n_bad++;
            $display("[TB] FAIL p1_read_rsp: got cycle %0d data %0d, want cycle %0d data %0d", rc, rd, acc + RD_LAT + 1, ref_mem[2]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tie();
        int start, a0a, a0b, a1, rc;
        logic [3:0] rd, d5;
        apply_reset();
        d5 = 4'($urandom_range(15, 0));
        start = cyc;
        plan_writes(2, 1, start);
        fork
            begin
                send(0, 1'b1, 4'd3, 4'd5, 1'b0, a0a, rc, rd);
                send(0, 1'b1, 4'd5, d5, 1'b0, a0b, rc, rd);
            end
            begin
                send(1, 1'b1, 4'd4, 4'd9, 1'b0, a1, rc, rd);
            end
        join
        ref_mem[3] = 4'd5;
        ref_mem[4] = 4'd9;
        ref_mem[5] = d5;
        n_cmp++;
        if (a0a !== exp0[0]) begin
            n_bad++;
            $display("[TB] FAIL tie_p0_first: got cycle %0d, want %0d", a0a, exp0[0]);
        end
        n_cmp++;
        if (a1 !== exp1[0]) begin
            n_bad++;
            $display("[TB] FAIL tie_p1: got cycle %0d, want %0d", a1, exp1[0]);
        end
        n_cmp++;
        if (a0b !== exp0[1]) begin
            n_bad++;
            $display("[TB] FAIL tie_p0_second: got cycle %0d, want %0d", a0b, exp0[1]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_latency();
        int start, acc, rc, w, n0, n1;
        logic [3:0] rd;
        n0 = rsp0_cnt;
        n1 = rsp1_cnt;
        start = cyc;
        w = winner(1'b1, 1'b0);
        send(0, 1'b0, 4'd3, 4'd0, 1'b1, acc, rc, rd);
        n_cmp++;
        if (acc !== start + 1 || rc !== acc + RD_LAT + 1) begin
            n_bad++;
            $display("[TB] FAIL rd_latency_p%0d: got accept %0d rsp %0d, want accept %0d rsp %0d", w, acc, rc, start + 1, start + RD_LAT + 2);
        end
        n_cmp++;
        if (rd !== ref_mem[3]) begin
            n_bad++;
            $display("[TB] FAIL rd_data_a3: got %0d, want %0d", rd, ref_mem[3]);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rsp0_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rsp0_one_pulse: got %b, want 0", bus.rsp0_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp0_cnt - n0 !== 1 || rsp1_cnt - n1 !== 0) begin
            n_bad++;
            $display("[TB] FAIL rsp_pulse_counts: got p0=%0d p1=%0d, want p0=1 p1=0", rsp0_cnt - n0, rsp1_cnt - n1);
        end
    endtask

    task automatic test_reset_during_read();
        int start, acc, rc, w, n1;
        logic [3:0] rd;
        n1 = rsp1_cnt;
        w = winner(1'b0, 1'b1);
        send(1, 1'b0, 4'd4, 4'd0, 1'b0, acc, rc, rd);
        apply_reset();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (rsp1_cnt !== n1) begin
            n_bad++;
            $display("[TB] FAIL no_rsp_after_reset: got %0d pulses, want 0", rsp1_cnt - n1);
        end
        n_cmp++;
        if (bus.mem_wr !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_mem_wr: got %b, want 0", bus.mem_wr);
        end
        start = cyc;
        w = winner(1'b0, 1'b1);
        send(1, 1'b0, 4'd4, 4'd0, 1'b1, acc, rc, rd);
        n_cmp++;
        if (acc !== start + 1 || rd !== ref_mem[4]) begin
            n_bad++;
            $display("[TB] FAIL read_after_reset_p%0d: got accept %0d data %0d, want accept %0d data %0d", w, acc, rd, start + 1, ref_mem[4]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int start, a1, rc;
        int a0 [3];
        logic [3:0] rd;
        logic [3:0] d [4];
        apply_reset();
        for (int i = 0; i < 4; i++) d[i] = 4'($urandom_range(15, 0));
        start = cyc;
        plan_writes(3, 1, start);
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    send(0, 1'b1, 4'(8 + i), d[i], 1'b0, a0[i], rc, rd);
                end
            end
            begin
                send(1, 1'b1, 4'd11, d[3], 1'b0, a1, rc, rd);
            end
        join
        for (int i = 0; i < 4; i++) ref_mem[8 + i] = d[i];
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (a0[i] !== exp0[i]) begin
                n_bad++;
                $display("[TB] FAIL b2b_p0_write%0d: got cycle %0d, want %0d", i, a0[i], exp0[i]);
            end
        end
        n_cmp++;
        if (a1 !== exp1[0]) begin
            n_bad++;
            $display("[TB] FAIL b2b_p1_held: got cycle %0d, want %0d", a1, exp1[0]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int start, w, l, acc0, acc1, rc0, rc1;
        int exp_acc [2];
        int acc [2];
        int rc [2];
        bit v [2];
        bit wr [2];
        logic [3:0] a [2];
        logic [3:0] d [2];
        logic [3:0] exp_d [2];
        logic [3:0] rd [2];
        logic [3:0] rd0, rd1;
        int order [2];
        int n_order;
        for (int it = 0; it < 40; it++) begin
            int mode = int'($urandom_range(3, 1));
            v[0] = mode[0];
            v[1] = mode[1];
            for (int p = 0; p < 2; p++) begin
                wr[p]    = 1'($urandom_range(1, 0));
                a[p]     = 4'($urandom_range(15, 0));
                d[p]     = 4'($urandom_range(15, 0));
                exp_d[p] = '0;
                exp_acc[p] = -1;
            end
            start = cyc;
            w = winner(v[0], v[1]);
            exp_acc[w] = start + 1;
            order[0] = w;
            n_order = 1;
            if (v[0] && v[1]) begin
                l = 1 - w;
                exp_acc[l] = start + 1 + (wr[w] ? 2 : RD_LAT + 2);
                void'(winner(l == 0, l == 1));
                order[1] = l;
                n_order = 2;
            end
            for (int k = 0; k < n_order; k++) begin
                if (wr[order[k]]) ref_mem[a[order[k]]] = d[order[k]];
                else exp_d[order[k]] = ref_mem[a[order[k]]];
            end
            acc0 = -1; acc1 = -1; rc0 = -1; rc1 = -1; rd0 = '0; rd1 = '0;
            fork
                begin
                    if (v[0]) send(0, wr[0], a[0], d[0], 1'b1, acc0, rc0, rd0);
                end
                begin
                    if (v[1]) send(1, wr[1], a[1], d[1], 1'b1, acc1, rc1, rd1);
                end
            join
            acc[0] = acc0; acc[1] = acc1;
            rc[0] = rc0; rc[1] = rc1;
            rd[0] = rd0; rd[1] = rd1;
            for (int p = 0; p < 2; p++) begin
                if (v[p]) begin
                    n_cmp++;
                    if (acc[p] !== exp_acc[p]) begin
                        n_bad++;
                        $display("[TB] FAIL rand%0d_accept_p%0d: got cycle %0d, want %0d", it, p, acc[p], exp_acc[p]);
                    end
                    if (!wr[p]) begin
                        n_cmp++;
                        if (rc[p] !== exp_acc[p] + RD_LAT + 1 || rd[p] !== exp_d[p]) begin
                            n_bad++;
                            $display("[TB] FAIL rand%0d_read_p%0d: got cycle %0d data %0d, want cycle %0d data %0d",
                                     it, p, rc[p], rd[p], exp_acc[p] + RD_LAT + 1, exp_d[p]);
                        end
                    end
                end
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_no_double_grant();
        n_cmp++;
        if (both_ready_cnt !== 0) begin
            n_bad++;
            $display("[TB] FAIL double_grant: got %0d cycles with both ready, want 0", both_ready_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 4'd0, 4'd0);
        test_reset();
        test_write_read();
        test_tie();
        test_read_latency();
        test_reset_during_read();
        test_back_to_back();
        test_random();
        test_no_double_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
